// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic register chain; PIPE_PARITY_EN adds one stored parity bit per stage.
// No logic of its own.
// Backpressure: n/a.
package pipe_pkg;

`ifdef PIPE_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Per-stage control: load enable from the ready chain, plus the broadcast flush.
  typedef struct packed {
    logic ld;
    logic flush;
  } stage_ctl_t;

  function automatic int CLOG2(input int n);
    int r;
    r = 0;
    for (int p = 1; p < n; p = p * 2) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register of the chain; data holds whenever the upstream slot is empty.
// Latency: 1 cycle.
// Backpressure: loads only when ctl.ld is set, and flush clears valid while keeping data.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int           W         = 64,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         clr_n,
  input  stage_ctl_t   ctl,
  input  logic         up_vld,
  input  logic [W-1:0] up_dat,
  output logic         vld,
  output logic [W-1:0] dat
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld <= 1'b0;
      dat <= RESET_VAL;
    end else if (ctl.flush) begin
      vld <= 1'b0;
    end else if (ctl.ld) begin
      vld <= up_vld;
      if (up_vld) dat <= up_dat;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// STAGES-deep elastic valid/ready register pipeline with flush, occupancy, and optional parity (PIPE_PARITY_EN).
// Latency: STAGES cycles when unstalled, 1 word/cycle throughput.
// Backpressure: empty stages collapse under stall, and in_ready drops only when every stage is full and out_ready is low.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [CLOG2(STAGES+1)-1:0]    occupancy,
  output logic                          parity_err
);

  localparam int SW    = WIDTH + PARITY_W;
  localparam int OCC_W = CLOG2(STAGES + 1);

`ifdef PIPE_PARITY_EN
  localparam logic [SW-1:0] STAGE_RST = {^RESET_VAL, RESET_VAL};
  logic [SW-1:0] in_word;
  assign in_word = {^in_data, in_data};
`else
  localparam logic [SW-1:0] STAGE_RST = RESET_VAL;
  logic [SW-1:0] in_word;
  assign in_word = in_data;
`endif

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [SW-1:0]     dat [STAGES];
  stage_ctl_t        ctl [STAGES];

  // A stage may load iff some stage at or after it is empty, or the consumer takes the
  // last word; expanded per stage rather than chained so no combinational loop appears.
  always_comb begin
    logic any_gap;
    any_gap = 1'b0;
    rdy     = '0;
    for (int k = 0; k < STAGES; k++) begin
      any_gap = 1'b0;
      for (int j = k; j < STAGES; j++) any_gap = any_gap | ~vld[j];
      rdy[k] = out_ready | any_gap;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ctl[k].ld    = rdy[k];
      ctl[k].flush = flush;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          up_vld;
    logic [SW-1:0] up_dat;

    if (k == 0) begin : g_head
      assign up_vld = in_valid;
      assign up_dat = in_word;
    end else begin : g_body
      assign up_vld = vld[k-1];
      assign up_dat = dat[k-1];
    end

    pipe_stage #(
      .W         (SW),
      .RESET_VAL (STAGE_RST)
    ) u_stage (
      .clk    (clk),
      .clr_n  (clr_n),
      .ctl    (ctl[k]),
      .up_vld (up_vld),
      .up_dat (up_dat),
      .vld    (vld[k]),
      .dat    (dat[k])
    );
  end

  // Flush blocks both handshakes in its own cycle; occupancy deliberately stays unmasked.
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld[STAGES-1] & ~flush;
  assign out_data  = dat[STAGES-1][WIDTH-1:0];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) occupancy = occupancy + OCC_W'(vld[k]);
  end

`ifdef PIPE_PARITY_EN
  assign parity_err = out_valid & ((^out_data) != dat[STAGES-1][WIDTH]);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain with a position-queue reference model checked every cycle.
module tb_pipe_reg_chain;

  localparam int          W  = 64;
  localparam int          S  = 2;
  localparam int          OW = $clog2(S + 1);
  localparam logic [W-1:0] RV = 64'h0000_0000_5A5A_5A5A;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [OW-1:0] occupancy;
  logic          parity_err;

  int total = 0;
  int bad   = 0;
  bit forcing = 1'b0;

  int           mpos [$];
  logic [W-1:0] mdat [$];
  logic [W-1:0] rx   [$];

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH     (W),
    .STAGES    (S),
    .RESET_VAL (RV)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .parity_err (parity_err)
  );

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ordered list of words with their slot index; each edge the head may leave,
  // every word then advances one slot unless the word ahead still sits directly in front.
  task automatic model_step();
    int  lim;
    int  np;
    bit  irdy;
    if (flush) begin
      mpos.delete();
      mdat.delete();
      return;
    end
    irdy = (mpos.size() < S) || out_ready;
    if (mpos.size() > 0 && mpos[0] == S - 1 && out_ready) begin
      void'(mpos.pop_front());
      void'(mdat.pop_front());
    end
    lim = S;
    foreach (mpos[i]) begin
      np      = (mpos[i] + 1 < lim) ? mpos[i] + 1 : lim - 1;
      mpos[i] = np;
      lim     = np;
    end
    if (in_valid && irdy) begin
      mpos.push_back(0);
      mdat.push_back(in_data);
    end
  endtask

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mpos.delete();
      mdat.delete();
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    int cnt;
    bit exp_ir;
    bit exp_ov;
    if (clr_n) begin
      cnt    = mpos.size();
      exp_ir = ((cnt < S) || out_ready) && !flush;
      exp_ov = (cnt > 0) && (mpos[0] == S - 1) && !flush;
      check("m_in_ready", W'(in_ready), W'(exp_ir));
      check("m_out_valid", W'(out_valid), W'(exp_ov));
      check("m_occupancy", W'(occupancy), W'(cnt));
      if (exp_ov && !forcing) check("m_out_data", out_data, mdat[0]);
      if (!forcing) check("m_parity_err", W'(parity_err), '0);
      if (out_valid && out_ready) rx.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] nxt;
    logic [31:0]  vpat;
    logic [31:0]  rpat;
    bit           acc;

    // Reset with a live producer
    clr_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b1;
    tick(); tick();
    at_neg();
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_occupancy", W'(occupancy), '0);
    check("rst_out_data", out_data, RV);
    check("rst_parity_err", W'(parity_err), '0);
    tick();
    clr_n = 1'b1; in_valid = 1'b0;
    at_neg();
    check("rst_rel_out_valid0", W'(out_valid), '0);
    tick();
    at_neg();
    check("rst_rel_out_valid1", W'(out_valid), '0);
    check("rst_rel_occupancy", W'(occupancy), '0);
    tick();

    // Streaming 1..8
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      at_neg();
      check("stream_in_ready", W'(in_ready), 64'd1);
      if (i == 2) begin
        check("stream_occ_after_first", W'(occupancy), 64'd1);
        check("stream_not_yet_valid", W'(out_valid), '0);
      end
      if (i == 3) begin
        check("stream_first_valid", W'(out_valid), 64'd1);
        check("stream_first_data", out_data, 64'h1);
      end
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("stream_rx_count", W'(rx.size()), 64'd8);
    for (int i = 0; i < 8; i++) check("stream_rx_order", rx[i], W'(i + 1));
    rx.delete();

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA1;
    at_neg(); check("bp_rdy_first", W'(in_ready), 64'd1);
    tick();
    in_data = 64'hA2;
    at_neg(); check("bp_rdy_second", W'(in_ready), 64'd1);
    tick();
    in_data = 64'hA3;
    at_neg();
    check("bp_full_in_ready", W'(in_ready), '0);
    check("bp_full_occ", W'(occupancy), 64'd2);
    check("bp_full_out_data", out_data, 64'hA1);
    tick();
    at_neg();
    check("bp_hold_out_data", out_data, 64'hA1);
    check("bp_hold_in_ready", W'(in_ready), '0);
    tick();
    out_ready = 1'b1;
    at_neg(); check("bp_release_in_ready", W'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("bp_rx_count", W'(rx.size()), 64'd3);
    check("bp_rx0", rx[0], 64'hA1);
    check("bp_rx1", rx[1], 64'hA2);
    check("bp_rx2", rx[2], 64'hA3);
    rx.delete();

    // Bubble collapse: last stage full and stalled, first stage empty
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hB1;
    tick();
    in_valid = 1'b0;
    tick();
    at_neg();
    check("bub_occ_one", W'(occupancy), 64'd1);
    check("bub_in_ready", W'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = 64'hB2;
    tick();
    in_valid = 1'b0;
    at_neg();
    check("bub_occ_two", W'(occupancy), 64'd2);
    check("bub_full_in_ready", W'(in_ready), '0);
    check("bub_out_data", out_data, 64'hB1);

    // Flush beats both handshakes
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hC1; out_ready = 1'b1;
    at_neg();
    check("fl_in_ready", W'(in_ready), '0);
    check("fl_out_valid", W'(out_valid), '0);
    check("fl_occ_unmasked", W'(occupancy), 64'd2);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    at_neg();
    check("fl_occ_cleared", W'(occupancy), '0);
    check("fl_out_valid_after", W'(out_valid), '0);
    check("fl_data_held", out_data, 64'hB1);
    tick(); tick();
    check("fl_no_output", W'(rx.size()), '0);

    // Reset in the middle of traffic
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hD1; tick();
    in_data = 64'hD2; tick();
    #2 clr_n = 1'b0;
    #1;
    check("mrst_occ", W'(occupancy), '0);
    check("mrst_out_valid", W'(out_valid), '0);
    check("mrst_out_data", out_data, RV);
    in_valid = 1'b0;
    tick();
    clr_n = 1'b1; out_ready = 1'b1;
    tick(); tick();
    check("mrst_no_output", W'(rx.size()), '0);

    // Mixed valid/ready/flush pattern, checked by the model each cycle
    vpat = 32'hB5E3_96CF;
    rpat = 32'h6D2B_F0E5;
    nxt  = 64'h100;
    in_valid = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (!in_valid && vpat[c]) begin
        in_valid = 1'b1;
        in_data  = nxt;
      end
      out_ready = rpat[c];
      flush     = (c == 20);
      at_neg();
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        nxt      = nxt + 1;
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    check("mix_drained", W'(occupancy), '0);
    rx.delete();

`ifdef PIPE_PARITY_EN
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h0F; tick();
    in_valid = 1'b0; tick();
    at_neg();
    check("par_clean", W'(parity_err), '0);
    forcing = 1'b1;
    force dut.g_stage[S-1].u_stage.dat = {1'b0, 64'h0E};
    at_neg();
    check("par_flip_detect", W'(parity_err), 64'd1);
    release dut.g_stage[S-1].u_stage.dat;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    forcing = 1'b0;
    tick();
    out_ready = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
